// File: rtl/digit_emitter.sv
// Binary-to-BCD (double dabble) converter that streams 8 digit writes, units first.
// Optional: define DIGIT_EMITTER_SAT_EN to show 99999999 when the value overflows 8 digits.
module digit_emitter #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [3:0]       dig_o,
  output logic [3:0]       pos_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam int unsigned CntW    = $clog2(WIDTH + 1);
  localparam logic [31:0] MaxDisp = 32'd99_999_999;

`ifdef DIGIT_EMITTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StConvert, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [35:0]      bcd_q, bcd_d;
  logic [35:0]      bcd_adj, bcd_step;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       dig_q, dig_d;
  logic [3:0]       pos_q, pos_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             last_step;

  assign last_step = (cnt_q == CntW'(WIDTH - 1));

  function automatic logic [3:0] emit_digit(input logic [3:0] d, input logic ovf);
    return (SatEn && ovf) ? 4'd9 : d;
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 9; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[34:0], bin_q[WIDTH-1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= 4'hF;
      pos_q   <= 4'hF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i)          state_d = StConvert;
      StConvert: if (last_step)        state_d = StEmit;
      StEmit:    if (pos_q == 4'd8)    state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    pos_d  = pos_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d  = value_i;
          bcd_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          ovf_d  = (32'(value_i) > MaxDisp);
          dig_d  = 4'hF;
          pos_d  = 4'hF;
        end
      end
      StConvert: begin
        // The BCD top bit is always 0, so rotating it into bin equals a plain shift.
        bin_d = {bin_q[WIDTH-2:0], bcd_adj[35]};
        bcd_d = bcd_step;
        cnt_d = cnt_q + CntW'(1);
        if (last_step) begin
          pos_d = 4'd1;
          dig_d = emit_digit(bcd_step[3:0], ovf_q);
        end
      end
      StEmit: begin
        if (pos_q == 4'd8) begin
          pos_d  = 4'hF;
          dig_d  = 4'hF;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          pos_d = pos_q + 4'd1;
          dig_d = emit_digit(bcd_q[{1'b0, pos_q[2:0], 2'b00} +: 4], ovf_q);
        end
      end
      default: begin
        pos_d  = 4'hF;
        dig_d  = 4'hF;
        busy_d = 1'b0;
      end
    endcase
  end

  assign dig_o  = dig_q;
  assign pos_o  = pos_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_digit_emitter.sv
// Bench for digit_emitter: directed and random values against a decimal-arithmetic model,
// with a model of the display controller's digit memory.
module tb_digit_emitter;

  localparam int unsigned W = 27;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] value = '0;
  logic [3:0]   dig, pos;
  logic         busy, done, ovf;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [3:0] ctrl [1:8];
  int         writes = 0;

  always #5 clock = ~clock;

  digit_emitter #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .value_i (value),
    .dig_o   (dig),
    .pos_o   (pos),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf)
  );

  // Display controller: accepts a write when pos is 1..8 and dig is 0..9.
  always @(posedge clock) begin
    if (!reset && pos >= 4'd1 && pos <= 4'd8 && dig <= 4'd9) begin
      ctrl[pos] <= dig;
      writes    <= writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected eight written digits (units in the low nibble) and overflow flag.
  task automatic model(input logic [W-1:0] v, output logic [31:0] d, output logic o);
    longint t;
    t = longint'(v);
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    o = (longint'(v) > 99999999);
`ifdef DIGIT_EMITTER_SAT_EN
    if (o) d = 32'h9999_9999;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      check("idle_dig", 32'(dig), 32'hF);
      check("idle_pos", 32'(pos), 32'hF);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  // Starts a conversion at the next rising edge and follows it edge by edge.
  task automatic run(input logic [W-1:0] v, input bit pulse, input int abort_at);
    logic [31:0] ed;
    logic        eo;
    int          w0;
    int          k;
    model(v, ed, eo);
    value = v;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    value = W'($urandom);
    w0 = writes;
    for (int e = 1; e <= int'(W) + 8; e++) begin
      if (pulse && (e == 10 || e == int'(W) + 3)) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      if (e == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_dig", 32'(dig), 32'hF);
        check("rst_pos", 32'(pos), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_writes", 32'(writes - w0), 32'd4);
        @(negedge clock);
        reset = 1'b0;
        repeat (int'(W) + 10) begin
          @(negedge clock);
          check("post_rst_done", 32'(done), 32'd0);
          check("post_rst_pos", 32'(pos), 32'hF);
        end
        check("post_rst_writes", 32'(writes - w0), 32'd4);
        return;
      end
      @(negedge clock);
      if (e < int'(W)) begin
        check("conv_dig", 32'(dig), 32'hF);
        check("conv_pos", 32'(pos), 32'hF);
        check("conv_busy", 32'(busy), 32'd1);
        check("conv_done", 32'(done), 32'd0);
      end else if (e < int'(W) + 8) begin
        k = e - int'(W) + 1;
        check("emit_pos", 32'(pos), 32'(k));
        check("emit_dig", 32'(dig), 32'(ed[4*(k-1) +: 4]));
        check("emit_busy", 32'(busy), 32'd1);
        check("emit_done", 32'(done), 32'd0);
      end else begin
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_dig", 32'(dig), 32'hF);
        check("fin_pos", 32'(pos), 32'hF);
      end
      if (e == 1) check("ovf_early", 32'(ovf), 32'(eo));
    end
    check("ovf", 32'(ovf), 32'(eo));
    check("write_count", 32'(writes - w0), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      check("ctrl_digit", 32'(ctrl[i]), 32'(ed[4*(i-1) +: 4]));
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset_dig", 32'(dig), 32'hF);
    check("reset_pos", 32'(pos), 32'hF);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    run(W'(12345678), 1'b0, 0);
    idle(1);
    run(W'(0), 1'b0, 0);
    idle(1);
    run(W'(99999999), 1'b0, 0);
    idle(1);
    run(W'(123456789), 1'b0, 0);
    idle(1);
    run(W'(134217727), 1'b0, 0);
    idle(1);

    // Ignored starts mid-conversion and mid-emit, then back-to-back start on done.
    run(W'(56473829), 1'b1, 0);
    run(W'(7), 1'b0, 0);
    idle(2);

    for (int n = 0; n < 8; n++) begin
      if (n % 2 == 0) run(W'($urandom_range(134217727, 0)), 1'b0, 0);
      else            run(W'($urandom_range(999, 0)), 1'b0, 0);
      if (n % 3 == 2) idle(1);
    end
    idle(1);

    run(W'(123456789), 1'b0, int'(W) + 4);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
